// File: rtl/kb_pkg.sv
// Register map and bit positions shared by the keyboard scancode FIFO
// and anything that talks to it over the CPU bus.
package kb_pkg;

    localparam logic [7:0] KB_DATA_OFS   = 8'h00;
    localparam logic [7:0] KB_STATUS_OFS = 8'h04;
    localparam logic [7:0] KB_CTRL_OFS   = 8'h08;

    localparam int KB_STAT_NOT_EMPTY_BIT = 0;
    localparam int KB_STAT_FULL_BIT      = 1;
    localparam int KB_STAT_OVF_BIT       = 2;
    localparam int KB_STAT_IRQ_EN_BIT    = 3;
    localparam int KB_STAT_COUNT_LSB     = 8;

    localparam int KB_CTRL_FLUSH_BIT   = 0;
    localparam int KB_CTRL_CLR_OVF_BIT = 1;
    localparam int KB_CTRL_IRQ_EN_BIT  = 2;

    localparam int KB_DATA_VALID_BIT = 31;

    // count arrives zero-extended, so bits above the real count width stay 0
    function automatic logic [31:0] kb_status_word(
        input logic        not_empty,
        input logic        full,
        input logic        ovf,
        input logic        irq_en,
        input logic [15:0] count
    );
        logic [31:0] word;
        word                        = 32'(count) << KB_STAT_COUNT_LSB;
        word[KB_STAT_NOT_EMPTY_BIT] = not_empty;
        word[KB_STAT_FULL_BIT]      = full;
        word[KB_STAT_OVF_BIT]       = ovf;
        word[KB_STAT_IRQ_EN_BIT]    = irq_en;
        return word;
    endfunction

endpackage

// File: rtl/kb_fifo_mem.sv
// Simple dual-port scancode RAM: one write port, one registered read port.
// A same-address read and write return the old contents.
module kb_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 128,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/kb_fifo_mmio.sv
// Memory-mapped keyboard scancode FIFO: the PS/2 side pushes scancodes,
// the CPU pops them through DATA and manages the queue through STATUS/CTRL.
module kb_fifo_mmio
    import kb_pkg::*;
#(
    parameter int         DATA_WIDTH  = 8,
    parameter int         DEPTH       = 128,
    parameter logic [3:0] BASE_NIBBLE = 4'h3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] kb_scancode_in,
    input  logic                  kb_valid_in,
    input  logic [31:0]           cpu_addr_in,
    input  logic                  cpu_read_enable_in,
    input  logic [3:0]            cpu_write_enable_in,
    input  logic [31:0]           cpu_data_in,
    output logic [31:0]           cpu_data_out,
    output logic                  irq_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          irq_en_q, irq_en_d;
    logic          irq_q;
    logic          resp_pop_q, resp_pop_d;
    logic [31:0]   resp_word_q, resp_word_d;

    logic                  sel, rd_sel, ctrl_wr, flush;
    logic                  empty, full, push, pop, ovf_evt;
    logic [7:0]            ofs;
    logic [31:0]           status_word;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  unused_bits;

    assign unused_bits = ^{cpu_addr_in[31:20], cpu_addr_in[15:8], cpu_data_in[31:3]};

    assign sel     = (cpu_addr_in[19:16] == BASE_NIBBLE);
    assign ofs     = cpu_addr_in[7:0];
    assign rd_sel  = cpu_read_enable_in && sel;
    assign ctrl_wr = sel && (|cpu_write_enable_in) && (ofs == KB_CTRL_OFS);
    assign flush   = ctrl_wr && cpu_data_in[KB_CTRL_FLUSH_BIT];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));

    // A pop frees the slot a same-cycle push lands in, so full+pop still accepts.
    assign pop     = rd_sel && (ofs == KB_DATA_OFS) && !empty && !flush;
    assign push    = kb_valid_in && (!full || pop) && !flush;
    assign ovf_evt = kb_valid_in && full && !pop && !flush;

    assign status_word = kb_status_word(!empty, full, ovf_q, irq_en_q, 16'(count_q));

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q | ovf_evt;
        irq_en_d    = irq_en_q;
        resp_pop_d  = resp_pop_q;
        resp_word_d = resp_word_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (ctrl_wr) begin
            if (cpu_data_in[KB_CTRL_CLR_OVF_BIT]) ovf_d = 1'b0;
            irq_en_d = cpu_data_in[KB_CTRL_IRQ_EN_BIT];
        end

        // The response is latched per read and held until the next read.
        if (cpu_read_enable_in) begin
            resp_pop_d  = pop;
            resp_word_d = (rd_sel && ofs == KB_STATUS_OFS) ? status_word : 32'h0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            resp_pop_q  <= 1'b0;
            resp_word_q <= 32'h0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_en_q && !empty;
            resp_pop_q  <= resp_pop_d;
            resp_word_q <= resp_word_d;
        end
    end

    kb_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_mem (
        .clk_i    (clk_in),
        .wr_en_i  (push && !rst_in),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(kb_scancode_in),
        .rd_en_i  (pop && !rst_in),
        .rd_addr_i(rd_ptr_q),
        .rd_data_o(mem_rd_data)
    );

    assign cpu_data_out = resp_pop_q
                        ? (32'(mem_rd_data) | (32'h1 << KB_DATA_VALID_BIT))
                        : resp_word_q;
    assign irq_out      = irq_q;

endmodule
